tdc_coarse_cnt_ctrl: RTL and testbench

Sequencing controller for the ETROC2 TDC coarse ripple counter. Per measurement it issues the counter reset pulse and arms the TOA and TOT latch clocks on hit events. After a settle window it samples the latched A/B counter pairs and consistency-checks them. It then presents one result word to the TDC readout through a valid/ready handshake.

---
 rtl/tdc_coarse_cnt_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_tdc_coarse_cnt_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_coarse_cnt_ctrl.sv
// -----------------------------------------------------------------------------
// tdc_coarse_cnt_ctrl
//
// Sequencing controller for the TDC coarse ripple counter. For each
// measurement it pulses the ripple-counter reset and raises the TOA and TOT
// latch clocks on their hit events. After a settle window it samples the
// latched A/B counter pairs, checks that the two copies agree, and offers
// one result word to the readout through a valid/ready handshake.
//
// Parameters
//   RST_LEN  cycles Cnt_RSTN is held low per measurement (1..15)
//   SETTLE   cycles from the last latch-clock edge to sampling (1..15)
//   TIMEOUT  cycles waited in each arm state before aborting (2..255)
//
// Ports
//   Clk_In               controller clock, rising edge
//   RSTN                 asynchronous active-low reset
//   Meas_Start           one-cycle measurement request (dropped while Busy)
//   TOA_Hit, TOT_Hit     synchronous discriminator events
//   TOA_CntA/B           latched TOA ripple counter copies
//   TOT_CntA/B           latched TOT ripple counter copies
//   Cnt_RSTN             ripple counter reset, active low
//   TOA_Clk, TOT_Clk     latch clocks, one rising edge per measurement
//   Busy                 high in every state except IDLE
//   TOA_Code, TOT_Code   resolved coarse codes
//   Code_Err             [0] TOA A/B mismatch, [1] TOT A/B mismatch
//   Timeout              measurement aborted because a hit never came
//   Data_Valid           result available
//   Data_Ready           readout accepts the result
// -----------------------------------------------------------------------------
module tdc_coarse_cnt_ctrl #(
  parameter int RST_LEN = 4,
  parameter int SETTLE  = 3,
  parameter int TIMEOUT = 64
) (
  input  logic       Clk_In,
  input  logic       RSTN,
  input  logic       Meas_Start,
  input  logic       TOA_Hit,
  input  logic       TOT_Hit,
  input  logic [2:0] TOA_CntA,
  input  logic [2:0] TOA_CntB,
  input  logic [2:0] TOT_CntA,
  input  logic [2:0] TOT_CntB,
  output logic       Cnt_RSTN,
  output logic       TOA_Clk,
  output logic       TOT_Clk,
  output logic       Busy,
  output logic [2:0] TOA_Code,
  output logic [2:0] TOT_Code,
  output logic [1:0] Code_Err,
  output logic       Timeout,
  output logic       Data_Valid,
  input  logic       Data_Ready
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_ARM_TOA,
    ST_ARM_TOT,
    ST_SETTLE,
    ST_CAPTURE,
    ST_OUT
  } state_t;

  // One shared cycle timer serves the reset, arm and settle windows; each
  // window compares against its own last-cycle value.
  localparam logic [7:0] RST_LAST     = 8'(RST_LEN - 1);
  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state_reg;
  logic [7:0] timer_reg;
  logic       cnt_rstn_reg;
  logic       toa_clk_reg;
  logic       tot_clk_reg;
  logic       busy_reg;
  logic [2:0] toa_code_reg;
  logic [2:0] tot_code_reg;
  logic [1:0] code_err_reg;
  logic       timeout_reg;
  logic       data_valid_reg;

  // ---------------------------------------------------------------------------
  // Per-channel A/B consistency. Channel 0 is TOA, channel 1 is TOT.
  // The two ripple copies may legitimately differ by one count when the
  // latch edge lands on a counter transition, so (A - B) mod 8 of 0 or 1 is
  // accepted. With a 3-bit wrapping difference that is exactly "upper two
  // bits clear".
  // ---------------------------------------------------------------------------
  logic [2:0] cnt_a [2];
  logic [2:0] cnt_b [2];
  logic [1:0] err_res;

  assign cnt_a[0] = TOA_CntA;
  assign cnt_b[0] = TOA_CntB;
  assign cnt_a[1] = TOT_CntA;
  assign cnt_b[1] = TOT_CntB;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic [2:0] diff;
      assign diff        = cnt_a[gi] - cnt_b[gi];
      assign err_res[gi] = diff[2] | diff[1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sequencer with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk_In or negedge RSTN) begin
    if (!RSTN) begin
      state_reg      <= ST_IDLE;
      timer_reg      <= '0;
      cnt_rstn_reg   <= 1'b1;
      toa_clk_reg    <= 1'b0;
      tot_clk_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      toa_code_reg   <= '0;
      tot_code_reg   <= '0;
      code_err_reg   <= '0;
      timeout_reg    <= 1'b0;
      data_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (Meas_Start) begin
            state_reg    <= ST_RESET;
            timer_reg    <= '0;
            cnt_rstn_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end

        ST_RESET: begin
          if (timer_reg == RST_LAST) begin
            state_reg    <= ST_ARM_TOA;
            timer_reg    <= '0;
            cnt_rstn_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 8'd1;
          end
        end

        ST_ARM_TOA: begin
          if (TOA_Hit) begin
            toa_clk_reg <= 1'b1;
            timer_reg   <= '0;
            // A coincident TOT hit is taken in the same cycle so both latch
            // clocks rise together and the TOT arm window is skipped.
            if (TOT_Hit) begin
              tot_clk_reg <= 1'b1;
              state_reg   <= ST_SETTLE;
            end else begin
              state_reg <= ST_ARM_TOT;
            end
          end else if (timer_reg == TIMEOUT_LAST) begin
            state_reg      <= ST_OUT;
            timeout_reg    <= 1'b1;
            toa_code_reg   <= '0;
            tot_code_reg   <= '0;
            code_err_reg   <= '0;
            data_valid_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 8'd1;
          end
        end

        ST_ARM_TOT: begin
          if (TOT_Hit) begin
            tot_clk_reg <= 1'b1;
            timer_reg   <= '0;
            state_reg   <= ST_SETTLE;
          end else if (timer_reg == TIMEOUT_LAST) begin
            // TOA_Clk is deliberately left high: it must not produce a second
            // rising edge before the handshake releases it.
            state_reg      <= ST_OUT;
            timeout_reg    <= 1'b1;
            toa_code_reg   <= '0;
            tot_code_reg   <= '0;
            code_err_reg   <= '0;
            data_valid_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 8'd1;
          end
        end

        ST_SETTLE: begin
          if (timer_reg == SETTLE_LAST) begin
            state_reg <= ST_CAPTURE;
          end else begin
            timer_reg <= timer_reg + 8'd1;
          end
        end

        ST_CAPTURE: begin
          // The A copy is reported in both the good and the mismatch case;
          // the error flag tells the readout whether to trust it.
          toa_code_reg   <= TOA_CntA;
          tot_code_reg   <= TOT_CntA;
          code_err_reg   <= err_res;
          timeout_reg    <= 1'b0;
          data_valid_reg <= 1'b1;
          state_reg      <= ST_OUT;
        end

        ST_OUT: begin
          // Result registers are only written on entry, so they stay stable
          // while the readout stalls. Codes and Timeout survive the handshake.
          if (Data_Ready) begin
            data_valid_reg <= 1'b0;
            toa_clk_reg    <= 1'b0;
            tot_clk_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            state_reg      <= ST_IDLE;
          end
        end

        default: begin
          state_reg      <= ST_IDLE;
          timer_reg      <= '0;
          cnt_rstn_reg   <= 1'b1;
          toa_clk_reg    <= 1'b0;
          tot_clk_reg    <= 1'b0;
          busy_reg       <= 1'b0;
          data_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign Cnt_RSTN   = cnt_rstn_reg;
  assign TOA_Clk    = toa_clk_reg;
  assign TOT_Clk    = tot_clk_reg;
  assign Busy       = busy_reg;
  assign TOA_Code   = toa_code_reg;
  assign TOT_Code   = tot_code_reg;
  assign Code_Err   = code_err_reg;
  assign Timeout    = timeout_reg;
  assign Data_Valid = data_valid_reg;

endmodule

// File: tb/tb_tdc_coarse_cnt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tdc_coarse_cnt_ctrl
//
// Self-checking bench. A timestamp-based model predicts, from the sequencing
// rules, when each output must be asserted (reset window, latch-clock rise
// times, result cycle, handshake cycle) and a compare process checks every
// output on every falling clock edge. Directed measurements add literal
// expectations computed by hand.
// -----------------------------------------------------------------------------
module tb_tdc_coarse_cnt_ctrl;

  localparam int RST_LEN = 4;
  localparam int SETTLE  = 3;
  localparam int TIMEOUT = 64;
  localparam int ARM     = RST_LEN + 1;  // ARM_TOA entry cycle after Meas_Start

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       meas_start = 1'b0;
  logic       toa_hit = 1'b0;
  logic       tot_hit = 1'b0;
  logic [2:0] toa_a = '0, toa_b = '0, tot_a = '0, tot_b = '0;
  logic       data_ready = 1'b0;
  logic       cnt_rstn, toa_clk, tot_clk, busy, timeout, data_valid;
  logic [2:0] toa_code, tot_code;
  logic [1:0] code_err;

  int checks = 0;
  int errors = 0;
  int printed = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  tdc_coarse_cnt_ctrl #(
    .RST_LEN(RST_LEN), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk_In    (clk),
    .RSTN      (rstn),
    .Meas_Start(meas_start),
    .TOA_Hit   (toa_hit),
    .TOT_Hit   (tot_hit),
    .TOA_CntA  (toa_a),
    .TOA_CntB  (toa_b),
    .TOT_CntA  (tot_a),
    .TOT_CntB  (tot_b),
    .Cnt_RSTN  (cnt_rstn),
    .TOA_Clk   (toa_clk),
    .TOT_Clk   (tot_clk),
    .Busy      (busy),
    .TOA_Code  (toa_code),
    .TOT_Code  (tot_code),
    .Code_Err  (code_err),
    .Timeout   (timeout),
    .Data_Valid(data_valid),
    .Data_Ready(data_ready)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      if (printed < 40)
        $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
      printed++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: every measurement is described by event times (cycle indices).
  //   t0     cycle Meas_Start was accepted
  //   arm_a  first cycle TOA hits count
  //   toa_t  cycle TOA_Clk is first high, tot_t likewise
  //   dv_t   first cycle Data_Valid is high
  //   hs_t   cycle the handshake completes (last Busy cycle)
  // Result outputs r_* hold from dv_t until the next result.
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int t0 = -1, arm_a = -1, toa_t = -1, tot_t = -1, dv_t = -1, hs_t = -1;
  bit to_flag = 1'b0;
  logic [2:0] r_toa = '0, r_tot = '0;
  logic [1:0] r_err = '0;
  logic       r_to = 1'b0;

  function automatic bit active_at(input int k);
    return (t0 >= 0) && (k >= t0 + 1) && ((hs_t < 0) || (k <= hs_t));
  endfunction

  function automatic bit mism(input logic [2:0] a, input logic [2:0] b);
    return (((int'(a) - int'(b)) + 8) % 8) > 1;
  endfunction

  always @(posedge clk or negedge rstn) begin
    int n;
    n = cyc;
    if (!rstn) begin
      t0 = -1; arm_a = -1; toa_t = -1; tot_t = -1; dv_t = -1; hs_t = -1;
      to_flag = 1'b0;
      r_toa = '0; r_tot = '0; r_err = '0; r_to = 1'b0;
    end else if (!active_at(n)) begin
      if (meas_start) begin
        t0 = n; arm_a = n + RST_LEN + 1;
        toa_t = -1; tot_t = -1; dv_t = -1; hs_t = -1; to_flag = 1'b0;
      end
    end else begin
      if (dv_t < 0 && toa_t < 0 && n >= arm_a) begin
        if (toa_hit) begin
          toa_t = n + 1;
          if (tot_hit) begin
            tot_t = n + 1;
            dv_t  = tot_t + SETTLE + 1;
          end
        end else if (n == arm_a + TIMEOUT - 1) begin
          dv_t = n + 1; to_flag = 1'b1;
        end
      end else if (dv_t < 0 && toa_t >= 0 && tot_t < 0 && n >= toa_t) begin
        if (tot_hit) begin
          tot_t = n + 1;
          dv_t  = tot_t + SETTLE + 1;
        end else if (n == toa_t + TIMEOUT - 1) begin
          dv_t = n + 1; to_flag = 1'b1;
        end
      end
      if (dv_t == n + 1) begin
        if (to_flag) begin
          r_toa = '0; r_tot = '0; r_err = '0; r_to = 1'b1;
        end else begin
          r_toa = toa_a; r_tot = tot_a;
          r_err = {mism(tot_a, tot_b), mism(toa_a, toa_b)};
          r_to  = 1'b0;
        end
      end
      if (dv_t >= 0 && n >= dv_t && hs_t < 0 && data_ready) hs_t = n;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    int k;
    bit act;
    if (chk_en) begin
      k   = cyc;
      act = active_at(k);
      chk("Cnt_RSTN",   int'(cnt_rstn),   int'(!((t0 >= 0) && (k >= t0 + 1) && (k <= t0 + RST_LEN))));
      chk("Busy",       int'(busy),       int'(act));
      chk("TOA_Clk",    int'(toa_clk),    int'(act && toa_t >= 0 && k >= toa_t));
      chk("TOT_Clk",    int'(tot_clk),    int'(act && tot_t >= 0 && k >= tot_t));
      chk("Data_Valid", int'(data_valid), int'(act && dv_t >= 0 && k >= dv_t));
      chk("TOA_Code",   int'(toa_code),   int'(r_toa));
      chk("TOT_Code",   int'(tot_code),   int'(r_tot));
      chk("Code_Err",   int'(code_err),   int'(r_err));
      chk("Timeout",    int'(timeout),    int'(r_to));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int txn = 0;

  // Runs one measurement. Hit offsets are relative to ARM_TOA entry (-1 =
  // never). Cycle 0 is the Meas_Start cycle. Returns observed event cycles.
  task automatic run_meas(input int toa_off, input int tot_off,
                          input logic [2:0] a0, input logic [2:0] b0,
                          input logic [2:0] a1, input logic [2:0] b1,
                          input int rdy_dly, input bit poke_start,
                          output int rst_low, output int toa_rise,
                          output int tot_rise, output int dv_at,
                          output int busy_cyc,
                          output logic [2:0] o_toa, output logic [2:0] o_tot,
                          output logic [1:0] o_err, output logic o_to);
    bit done;
    done = 1'b0;
    rst_low = 0; toa_rise = -1; tot_rise = -1; dv_at = -1; busy_cyc = 0;
    o_toa = '0; o_tot = '0; o_err = '0; o_to = 1'b0;
    toa_a = a0; toa_b = b0; tot_a = a1; tot_b = b1;
    meas_start = 1'b1;
    tick();
    meas_start = 1'b0;
    for (int c = 1; c < 400 && !done; c++) begin
      if (!cnt_rstn) rst_low++;
      if (busy) busy_cyc++;
      if (toa_clk && toa_rise < 0) toa_rise = c;
      if (tot_clk && tot_rise < 0) tot_rise = c;
      if (data_valid && dv_at < 0) begin
        dv_at = c;
        o_toa = toa_code; o_tot = tot_code; o_err = code_err; o_to = timeout;
      end
      toa_hit    = (toa_off >= 0) && (c == ARM + toa_off);
      tot_hit    = (tot_off >= 0) && (c == ARM + tot_off);
      meas_start = poke_start && (dv_at >= 0) && (c == dv_at + 3);
      data_ready = (dv_at >= 0) && (c >= dv_at + rdy_dly);
      if (data_valid && data_ready) done = 1'b1;
      tick();
    end
    toa_hit = 1'b0; tot_hit = 1'b0; meas_start = 1'b0; data_ready = 1'b0;
    chk("handshake_reached", int'(done), 1);
    chk("busy_after_handshake", int'(busy), 0);
    txn++;
    $display("txn %0d: toa_code=%0d tot_code=%0d code_err=%b timeout=%b toa_rise=%0d tot_rise=%0d dv_at=%0d",
             txn, o_toa, o_tot, o_err, o_to, toa_rise, tot_rise, dv_at);
  endtask

  initial begin
    int rl, tr, sr, dv, bc;
    logic [2:0] ct, cs;
    logic [1:0] ce;
    logic       cto;

    #2 rstn = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_Cnt_RSTN", int'(cnt_rstn), 1);
    chk("rst_Busy", int'(busy), 0);
    chk("rst_Data_Valid", int'(data_valid), 0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // 1: nominal, codes agree
    run_meas(10, 20, 3'd5, 3'd5, 3'd2, 3'd1, 0, 1'b0, rl, tr, sr, dv, bc, ct, cs, ce, cto);
    chk("t1_rst_low", rl, 4);
    chk("t1_toa_rise", tr, 16);
    chk("t1_dv_after_tot", dv - sr, 4);
    chk("t1_toa_code", int'(ct), 5);
    chk("t1_tot_code", int'(cs), 2);
    chk("t1_code_err", int'(ce), 0);
    tick();

    // 2: TOA wraps by one (accepted), TOT off by five (flagged)
    run_meas(10, 20, 3'd0, 3'd7, 3'd3, 3'd6, 0, 1'b0, rl, tr, sr, dv, bc, ct, cs, ce, cto);
    chk("t2_toa_code", int'(ct), 0);
    chk("t2_tot_code", int'(cs), 3);
    chk("t2_code_err", int'(ce), 2);

    // 3: coincident hits on arm entry, ready early: minimum-length measurement
    run_meas(0, 0, 3'd4, 3'd3, 3'd1, 3'd3, 0, 1'b0, rl, tr, sr, dv, bc, ct, cs, ce, cto);
    chk("t3_toa_rise", tr, 6);
    chk("t3_tot_rise", sr, 6);
    chk("t3_dv_at", dv, 10);
    chk("t3_busy_cycles", bc, RST_LEN + SETTLE + 3);
    chk("t3_code_err", int'(ce), 2);
    tick();

    // 4: TOT before TOA is ignored, then no TOT: timeout in ARM_TOT
    run_meas(4, 1, 3'd6, 3'd6, 3'd5, 3'd5, 0, 1'b0, rl, tr, sr, dv, bc, ct, cs, ce, cto);
    chk("t4_toa_rise", tr, 10);
    chk("t4_tot_never", sr, -1);
    chk("t4_dv_at", dv, 74);
    chk("t4_timeout", int'(cto), 1);
    chk("t4_codes_zero", int'({ct, cs, ce}), 0);
    tick();

    // 5: no TOA at all: timeout in ARM_TOA
    run_meas(-1, -1, 3'd3, 3'd3, 3'd3, 3'd3, 0, 1'b0, rl, tr, sr, dv, bc, ct, cs, ce, cto);
    chk("t5_dv_at", dv, 69);
    chk("t5_toa_never", tr, -1);
    chk("t5_timeout", int'(cto), 1);
    tick();

    // 6: readout stalls 10 cycles, Meas_Start in the stall is dropped
    run_meas(2, 5, 3'd7, 3'd6, 3'd4, 3'd4, 10, 1'b1, rl, tr, sr, dv, bc, ct, cs, ce, cto);
    chk("t6_dv_at", dv, 15);
    chk("t6_busy_cycles", bc, 25);
    chk("t6_timeout_cleared", int'(cto), 0);
    chk("t6_toa_code", int'(ct), 7);
    tick(); tick();
    chk("t6_still_idle", int'(busy), 0);

    // 7: reset asserted during ARM_TOT
    meas_start = 1'b1;
    tick();
    meas_start = 1'b0;
    for (int c = 1; c < ARM + 4; c++) begin
      toa_hit = (c == ARM + 1);
      tick();
    end
    toa_hit = 1'b0;
    chk("t7_toa_clk_before", int'(toa_clk), 1);
    rstn = 1'b0;
    #1;
    chk("t7_toa_clk_reset", int'(toa_clk), 0);
    chk("t7_busy_reset", int'(busy), 0);
    chk("t7_cnt_rstn_reset", int'(cnt_rstn), 1);
    chk("t7_codes_reset", int'({toa_code, tot_code}), 0);
    tick(); tick();
    rstn = 1'b1;
    tick();
    run_meas(10, 20, 3'd5, 3'd5, 3'd2, 3'd1, 0, 1'b0, rl, tr, sr, dv, bc, ct, cs, ce, cto);
    chk("t7_rst_low", rl, 4);
    chk("t7_toa_code", int'(ct), 5);
    chk("t7_tot_code", int'(cs), 2);
    chk("t7_code_err", int'(ce), 0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
